// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, request legality.
package lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // True when the size code is not legal for the direction or the address is misaligned.
   function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (we) begin
         case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = |addr_lo;
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = |addr_lo;
            default:     bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering: extracts and extends load data, or merges sub-word store data into a word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic            sel_store,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rdata,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] result
);

   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] ld_val;
   logic [XLEN-1:0] merged;

   always_comb begin
      lane_b = rdata[7:0];
      case (addr_lo)
         2'd0: lane_b = rdata[7:0];
         2'd1: lane_b = rdata[15:8];
         2'd2: lane_b = rdata[23:16];
         2'd3: lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    ld_val = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_val = {24'd0, lane_b};
         F3_H:    ld_val = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_val = {16'd0, lane_h};
         default: ld_val = rdata;
      endcase

      merged = rdata;
      case (funct3)
         F3_B: begin
            case (addr_lo)
               2'd0: merged[7:0]   = wdata[7:0];
               2'd1: merged[15:8]  = wdata[7:0];
               2'd2: merged[23:16] = wdata[7:0];
               2'd3: merged[31:24] = wdata[7:0];
               default: merged = rdata;
            endcase
         end
         F3_H: begin
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase

      result = sel_store ? merged : ld_val;
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed memory; sub-word stores use read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN: requests with nonzero address bits above the memory range error out.
//
// state | meaning
// IDLE  | ready for a request; rsp_valid pulses here after RESP
// READ  | memory word being read for a load or a sub-word merge
// WRITE | mem_we high for the whole cycle, memory writes at its negedge
// RESP  | final cycle before the completion pulse
module load_store_unit #(
   parameter int ADDR_W = 8,
   parameter int XLEN   = lsu_pkg::XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);
   import lsu_pkg::*;

   lsu_state_e      state;
   logic            cap_we;
   logic [1:0]      cap_lo;
   logic [2:0]      cap_f3;
   logic [XLEN-1:0] cap_wdata;
   logic [XLEN-1:0] lane_out;
   logic            acc_err;

`ifdef LSU_BOUNDS_CHECK_EN
   always_comb begin
      acc_err = req_illegal(req_we, req_funct3, req_addr[1:0]);
      if (|req_addr[XLEN-1:ADDR_W+2]) acc_err = 1'b1;
   end
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];

   always_comb begin
      acc_err = req_illegal(req_we, req_funct3, req_addr[1:0]);
   end
`endif

   lsu_byte_lane u_lane (
      .sel_store (cap_we),
      .addr_lo   (cap_lo),
      .funct3    (cap_f3),
      .rdata     (mem_rdata),
      .wdata     (cap_wdata),
      .result    (lane_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cap_we    <= 1'b0;
         cap_lo    <= 2'd0;
         cap_f3    <= 3'd0;
         cap_wdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  cap_we    <= req_we;
                  cap_lo    <= req_addr[1:0];
                  cap_f3    <= req_funct3;
                  cap_wdata <= req_wdata;
                  rsp_rdata <= '0;
                  rsp_err   <= acc_err;
                  req_ready <= 1'b0;
                  if (acc_err) begin
                     state <= RESP;
                  end else begin
                     mem_addr <= req_addr[ADDR_W+1:2];
                     // Full-word stores need no merge and skip the read.
                     if (req_we && req_funct3 == F3_W) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= req_wdata;
                        state     <= WRITE;
                     end else begin
                        state <= READ;
                     end
                  end
               end
            end
            READ: begin
               if (cap_we) begin
                  mem_wdata <= lane_out;
                  mem_we    <= 1'b1;
                  state     <= WRITE;
               end else begin
                  rsp_rdata <= lane_out;
                  state     <= RESP;
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               state  <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               mem_we    <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory port (synchronous write on negedge clk, combinational read).
- Accepts RV32I load/store requests from the execute stage: byte address, funct3 size/sign code, store data.
- Drives the memory's we/address/dataIn and reads its dataOut.
- Sub-word stores use read-modify-write; loads return sign/zero-extended data.

Parameters:
- ADDR_W, 8, memory word-address width (memory holds 2**ADDR_W words)
- XLEN, 32, data width; fixed at 32

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; qualified by rsp_valid
- mem_we  out  1  memory write enable; registered
- mem_addr  out  ADDR_W  memory word address; registered
- mem_wdata  out  32  memory write data; registered
- mem_rdata  in  32  memory read data (combinational from mem_addr)

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - All request fields are captured at acceptance. The requester may change them afterwards.
  - No response backpressure. rsp_valid is high for exactly one cycle.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored (wrap-around modulo 2**ADDR_W words).
- Error check at acceptance:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load 011/110/111; store anything other than 000/001/010.
  - Error path: IDLE -> RESP with rsp_err=1, rsp_rdata=0. No memory access; mem_we stays 0.
- Load (LB/LH/LW/LBU/LHU):
  - IDLE -> READ, with mem_addr loaded at acceptance.
  - At the READ edge: capture mem_rdata, select the byte/halfword lane from addr[1:0], sign- or zero-extend into rsp_rdata, go to RESP.
  - RESP -> IDLE.
  - rsp_valid rises 2 cycles after the accept edge.
- SW: IDLE -> WRITE. mem_we=1 and mem_wdata=req_wdata for one full cycle, so the memory writes at that cycle's negedge. Then WRITE -> RESP. Latency 2.
- SB/SH:
  - IDLE -> READ -> WRITE -> RESP. Latency 3.
  - In READ, capture mem_rdata and merge the low byte/halfword of req_wdata into lane addr[1:0].
  - In WRITE, mem_wdata = merged word.
- Lanes: byte lane n occupies bits [8n+7:8n]; halfword at addr[1]=1 occupies bits [31:16].
- mem_we is high only in WRITE, and mem_addr is stable for the whole WRITE cycle. This guarantees exactly one negedge write per store.
- mem_addr holds its last value in IDLE/RESP. mem_rdata is ignored outside READ.
- Reset mid-operation:
  - Abort immediately: mem_we drops asynchronously; no rsp_valid is issued for the aborted request.
  - A write whose negedge has not yet occurred is lost.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: at acceptance, any request with req_addr[31:ADDR_W+2] != 0 takes the error path (rsp_err=1, no memory access).
- Undefined: upper address bits are ignored and the address wraps.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding
  - XLEN constant
- One combinational sub-module, lsu_byte_lane, performs both jobs from addr[1:0], funct3 and a load/store select:
  - load extract and extension
  - store merge
- load_store_unit keeps the FSM and registers.

Test Plan:
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> mem_we high for one cycle with mem_addr 4; rsp_valid 2 cycles after accept, rsp_err 0. Then LW 0x10 -> rsp_rdata 0xDEADBEEF at latency 2.
- After the above, SB addr 0x11 wdata 0x0000_0055 -> READ then WRITE with mem_wdata 0xDEAD55EF; latency 3. LBU 0x11 -> 0x0000_0055; LB 0x13 -> 0xFFFF_FFDE.
- SH addr 0x12 wdata 0x1234 -> word 0x123455EF. LH 0x12 -> 0x0000_1234; LHU 0x10 -> 0x0000_55EF.
- LW 0x0000_0006 and SH 0x0000_0003 -> rsp_err 1, rsp_rdata 0, mem_we never asserted, latency 1. Load funct3 011 -> rsp_err 1.
- Assert rst during WRITE of an SB before the negedge -> mem_we low immediately, memory word unchanged, no rsp_valid, req_ready 1 after reset release.
- SW addr 0x0000_0400 (ADDR_W=8) -> without LSU_BOUNDS_CHECK_EN, writes mem_addr 0. With the macro, rsp_err 1 and no write.
